// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: holds the PC, issues instruction-memory
// fetches, and presents one instruction per EXEC cycle to the decoder.
module pc_sequencer #(
  parameter int unsigned           PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0]   START_ADDR = PC_WIDTH'(0)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                jump_en,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_req,
  input  logic                imem_ack,
  output logic                instr_valid,
  output logic                done,
  output logic [PC_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] count;
  logic [PC_WIDTH-1:0] count_next;

  // State, PC, count and the state-decoded outputs, all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= START_ADDR;
      count       <= PC_WIDTH'(0);
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      count       <= count_next;
      imem_req    <= (state_next == S_FETCH);
      instr_valid <= (state_next == S_EXEC);
      done        <= (state_next == S_HALTED);
    end
  end

  // Next-state, next-PC and instruction counter; halt outranks jump in EXEC.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    count_next = count;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          pc_next    = START_ADDR;
          count_next = PC_WIDTH'(0);
        end
      end
      S_FETCH: begin
        if (imem_ack) state_next = S_EXEC;
      end
      S_EXEC: begin
        count_next = (count == {PC_WIDTH{1'b1}}) ? count : count + PC_WIDTH'(1);
        if (halt) begin
          state_next = S_HALTED;
        end else if (jump_en) begin
          state_next = S_FETCH;
          pc_next    = jump_target;
        end else begin
          state_next = S_FETCH;
          pc_next    = pc + PC_WIDTH'(1);
        end
      end
      S_HALTED: begin
        if (start) begin
          state_next = S_FETCH;
          pc_next    = START_ADDR;
          count_next = PC_WIDTH'(0);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign imem_addr   = pc;
  assign instr_count = count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a second instance with START_ADDR 0xFFFF
// shares the stimulus to exercise PC wrap.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        jump_en;
  logic [15:0] jump_target;
  logic        halt;
  logic        imem_ack;

  logic [15:0] imem_addr, instr_count, imem_addr_w, instr_count_w;
  logic        imem_req, instr_valid, done, imem_req_w, instr_valid_w, done_w;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_WIDTH(16), .START_ADDR(16'h0000)) dut (
    .clk(clk), .reset(reset), .start(start), .jump_en(jump_en),
    .jump_target(jump_target), .halt(halt), .imem_addr(imem_addr),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr_valid(instr_valid),
    .done(done), .instr_count(instr_count)
  );

  pc_sequencer #(.PC_WIDTH(16), .START_ADDR(16'hFFFF)) dut_w (
    .clk(clk), .reset(reset), .start(start), .jump_en(jump_en),
    .jump_target(jump_target), .halt(halt), .imem_addr(imem_addr_w),
    .imem_req(imem_req_w), .imem_ack(imem_ack), .instr_valid(instr_valid_w),
    .done(done_w), .instr_count(instr_count_w)
  );

  // {imem_req, instr_valid, done, imem_addr, instr_count}
  wire [34:0] obs   = {imem_req, instr_valid, done, imem_addr, instr_count};
  wire [34:0] obs_w = {imem_req_w, instr_valid_w, done_w, imem_addr_w, instr_count_w};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; jump_en = 1'b0; halt = 1'b0;
    jump_target = 16'h0000; imem_ack = 1'b0;
    tick();
    tick();
    vectors++;
    if (obs !== {3'b000, 16'h0000, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_hold got=%h exp=%h", obs, {3'b000, 16'h0000, 16'd0});
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (obs !== {3'b000, 16'h0000, 16'd0}) begin
        miscompares++;
        $display("FAIL idle_cycle%0d got=%h exp=%h", i, obs, {3'b000, 16'h0000, 16'd0});
      end
    end
  endtask

  task automatic test_sequential();
    start = 1'b1; imem_ack = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs !== {3'b100, 16'(i), 16'(i)}) begin
        miscompares++;
        $display("FAIL seq_fetch%0d got=%h exp=%h", i, obs, {3'b100, 16'(i), 16'(i)});
      end
      tick();
      vectors++;
      if (obs !== {3'b010, 16'(i), 16'(i)}) begin
        miscompares++;
        $display("FAIL seq_exec%0d got=%h exp=%h", i, obs, {3'b010, 16'(i), 16'(i)});
      end
      tick();
    end
    imem_ack = 1'b0;
    vectors++;
    if (obs !== {3'b100, 16'h0003, 16'd3}) begin
      miscompares++;
      $display("FAIL seq_count3 got=%h exp=%h", obs, {3'b100, 16'h0003, 16'd3});
    end
  endtask

  task automatic test_jump_waitstates();
    tick();
    vectors++;
    if (obs !== {3'b100, 16'h0003, 16'd3}) begin
      miscompares++;
      $display("FAIL fetch_hold got=%h exp=%h", obs, {3'b100, 16'h0003, 16'd3});
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    imem_ack = 1'b1;
    tick();
    vectors++;
    if (obs !== {3'b010, 16'h0004, 16'd4}) begin
      miscompares++;
      $display("FAIL exec_at4 got=%h exp=%h", obs, {3'b010, 16'h0004, 16'd4});
    end
    jump_en = 1'b1; jump_target = 16'h0027; imem_ack = 1'b0;
    tick();
    // jump/halt during FETCH must be ignored
    jump_en = 1'b1; halt = 1'b1; jump_target = 16'h0099;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (obs !== {3'b100, 16'h0027, 16'd5}) begin
        miscompares++;
        $display("FAIL jump_wait%0d got=%h exp=%h", i, obs, {3'b100, 16'h0027, 16'd5});
      end
      if (i == 3) begin
        imem_ack = 1'b1; jump_en = 1'b0; halt = 1'b0;
      end
      tick();
    end
    vectors++;
    if (obs !== {3'b010, 16'h0027, 16'd5}) begin
      miscompares++;
      $display("FAIL exec_at27 got=%h exp=%h", obs, {3'b010, 16'h0027, 16'd5});
    end
    imem_ack = 1'b0;
    tick();
    vectors++;
    if (obs !== {3'b100, 16'h0028, 16'd6}) begin
      miscompares++;
      $display("FAIL step_after_jump got=%h exp=%h", obs, {3'b100, 16'h0028, 16'd6});
    end
  endtask

  task automatic test_wrap_priority();
    reset = 1'b1;
    tick();
    vectors++;
    if (obs_w !== {3'b000, 16'hFFFF, 16'd0}) begin
      miscompares++;
      $display("FAIL wrap_reset got=%h exp=%h", obs_w, {3'b000, 16'hFFFF, 16'd0});
    end
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    vectors++;
    if (obs_w !== {3'b100, 16'h0000, 16'd1}) begin
      miscompares++;
      $display("FAIL wrap_pc got=%h exp=%h", obs_w, {3'b100, 16'h0000, 16'd1});
    end
    imem_ack = 1'b1;
    tick();
    halt = 1'b1; jump_en = 1'b1; jump_target = 16'h0012; start = 1'b1; imem_ack = 1'b0;
    tick();
    halt = 1'b0; jump_en = 1'b0; start = 1'b0;
    vectors++;
    if (obs_w !== {3'b001, 16'h0000, 16'd2}) begin
      miscompares++;
      $display("FAIL halt_prio_w got=%h exp=%h", obs_w, {3'b001, 16'h0000, 16'd2});
    end
    vectors++;
    if (obs !== {3'b001, 16'h0001, 16'd2}) begin
      miscompares++;
      $display("FAIL halt_prio got=%h exp=%h", obs, {3'b001, 16'h0001, 16'd2});
    end
    tick();
    vectors++;
    if (obs !== {3'b001, 16'h0001, 16'd2}) begin
      miscompares++;
      $display("FAIL halted_stay got=%h exp=%h", obs, {3'b001, 16'h0001, 16'd2});
    end
  endtask

  task automatic test_restart_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; imem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 4) halt = 1'b1;
      tick();
      halt = 1'b0;
    end
    imem_ack = 1'b0;
    vectors++;
    if (obs !== {3'b001, 16'h0004, 16'd5}) begin
      miscompares++;
      $display("FAIL halted_count5 got=%h exp=%h", obs, {3'b001, 16'h0004, 16'd5});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (obs !== {3'b100, 16'h0000, 16'd0}) begin
      miscompares++;
      $display("FAIL restart got=%h exp=%h", obs, {3'b100, 16'h0000, 16'd0});
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (obs !== {3'b000, 16'h0000, 16'd0}) begin
      miscompares++;
      $display("FAIL midfetch_reset got=%h exp=%h", obs, {3'b000, 16'h0000, 16'd0});
    end
    start = 1'b1;
    tick();
    vectors++;
    if (obs !== {3'b000, 16'h0000, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_over_start got=%h exp=%h", obs, {3'b000, 16'h0000, 16'd0});
    end
    reset = 1'b0; start = 1'b0;
    tick();
    vectors++;
    if (obs !== {3'b000, 16'h0000, 16'd0}) begin
      miscompares++;
      $display("FAIL idle_after_reset got=%h exp=%h", obs, {3'b000, 16'h0000, 16'd0});
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump_waitstates();
    test_wrap_priority();
    test_restart_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
